// File: rtl/ultrasonic_scan_scheduler.sv
`timescale 1ns/1ps
// Round-robin HC-SR04 scheduler: one shared echo timer triggers each enabled sensor in turn and stores cm results.
// Result appears one cycle after echo fall/timeout; no backpressure, dist_valid is a fire-and-forget strobe.
module ultrasonic_scan_scheduler #(
  parameter int N_SENSORS    = 4,
  parameter int CLK_FREQ_MHZ = 125,
  parameter int TRIG_US      = 10,
  parameter int ECHO_WAIT_US = 30000,
  parameter int MAX_ECHO_US  = 25000,
  parameter int GAP_US       = 60000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [N_SENSORS-1:0]         sensor_mask,
  input  logic [N_SENSORS-1:0]         echo,
  output logic [N_SENSORS-1:0]         trig,
  output logic [16*N_SENSORS-1:0]      dist_flat,
  output logic                         dist_valid,
  output logic [$clog2(N_SENSORS)-1:0] dist_sel,
  output logic [N_SENSORS-1:0]         err_flags,
  output logic                         busy
);

  localparam int SW = $clog2(N_SENSORS);
  localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_MHZ - 1);
  localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0] WAIT_LAST = 16'(ECHO_WAIT_US - 1);
  localparam logic [15:0] ECHO_LAST = 16'(MAX_ECHO_US - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_US - 1);
  localparam logic [15:0] NO_RESULT = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, STORE, GAP} state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic            us_tick;
  logic [N_SENSORS-1:0] echo_m, echo_s, echo_d;
  logic [SW-1:0]   sel, ptr, nxt, sel_inc;
  logic [15:0]     tcnt, us_cnt, cm_cnt, result;
  logic [5:0]      sub58;
  logic            res_err;
  logic            echo_rise, echo_fall, mask_any, start;

  // First masked-in sensor at or after p, wrapping past the last sensor.
  function automatic logic [SW-1:0] pick(input logic [N_SENSORS-1:0] m, input logic [SW-1:0] p);
    logic [SW-1:0] r;
    logic [SW:0]   j;
    logic          found;
    r     = p;
    found = 1'b0;
    for (int i = 0; i < N_SENSORS; i++) begin
      j = {1'b0, p} + (SW+1)'(i);
      if (j >= (SW+1)'(N_SENSORS)) j = j - (SW+1)'(N_SENSORS);
      if (!found && m[j[SW-1:0]]) begin
        r     = j[SW-1:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    us_tick   = (state != IDLE) && (presc == PRESC_LAST);
    echo_rise = echo_s[sel] & ~echo_d[sel];
    echo_fall = ~echo_s[sel] & echo_d[sel];
    mask_any  = |sensor_mask;
    nxt       = pick(sensor_mask, ptr);
    sel_inc   = (sel == SW'(N_SENSORS - 1)) ? '0 : sel + SW'(1);
    start     = enable && mask_any &&
                ((state == IDLE) || (state == GAP && us_tick && tcnt == GAP_LAST));
  end

  assign dist_sel = sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= '0;
      trig       <= '0;
      dist_flat  <= '0;
      dist_valid <= 1'b0;
      err_flags  <= '0;
      busy       <= 1'b0;
      sel        <= '0;
      ptr        <= '0;
      tcnt       <= '0;
      us_cnt     <= '0;
      cm_cnt     <= '0;
      sub58      <= '0;
      result     <= '0;
      res_err    <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      if (state != IDLE) presc <= us_tick ? '0 : presc + PW'(1);

      case (state)
        IDLE: ;
        TRIG: begin
          if (us_tick) begin
            if (tcnt == TRIG_LAST) begin
              trig  <= '0;
              tcnt  <= '0;
              state <= WAIT_ECHO;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
        end
        WAIT_ECHO: begin
          if (echo_rise) begin
            us_cnt <= '0;
            cm_cnt <= '0;
            sub58  <= '0;
            state  <= MEASURE;
          end else if (us_tick) begin
            if (tcnt == WAIT_LAST) begin
              result  <= NO_RESULT;
              res_err <= 1'b1;
              state   <= STORE;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            result  <= cm_cnt;
            res_err <= 1'b0;
            state   <= STORE;
          end else if (us_tick) begin
            // 58 us of echo per cm: a mod-58 sub-counter replaces the divider.
            us_cnt <= us_cnt + 16'd1;
            if (sub58 == 6'd57) begin
              sub58  <= '0;
              cm_cnt <= cm_cnt + 16'd1;
            end else begin
              sub58 <= sub58 + 6'd1;
            end
            if (us_cnt == ECHO_LAST) begin
              result  <= NO_RESULT;
              res_err <= 1'b1;
              state   <= STORE;
            end
          end
        end
        STORE: begin
          for (int k = 0; k < N_SENSORS; k++) begin
            if (sel == SW'(k)) begin
              dist_flat[16*k +: 16] <= result;
              err_flags[k]          <= res_err;
            end
          end
          dist_valid <= 1'b1;
          ptr        <= sel_inc;
          tcnt       <= '0;
          state      <= GAP;
        end
        GAP: begin
          if (us_tick) begin
            if (tcnt == GAP_LAST) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Selection and trigger launch shared by IDLE and the end of GAP.
      if (start) begin
        sel   <= nxt;
        trig  <= {{(N_SENSORS-1){1'b0}}, 1'b1} << nxt;
        presc <= '0;
        tcnt  <= '0;
        busy  <= 1'b1;
        state <= TRIG;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
`timescale 1ns/1ps
// Directed bench for ultrasonic_scan_scheduler with a scaled timebase (2 clocks per us).
module tb_ultrasonic_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  sensor_mask;
  logic [3:0]  echo_pin;
  logic [3:0]  trig;
  logic [63:0] dist_flat;
  logic        dist_valid;
  logic [1:0]  dist_sel;
  logic [3:0]  err_flags;
  logic        busy;

  logic [3:0]  echo_r = '0;
  int          echo_w [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  int          rise_cnt [4];
  int          rises_total = 0;
  int          tw = 0;
  int          last_tw = 0;
  int          multi_hot = 0;
  logic [3:0]  tm_prev = '0;

  int          exp_sel [6] = '{1, 3, 0, 1, 3, 0};
  int          exp_val [6] = '{5, 10, 2, 5, 10, 2};

  assign echo_pin = echo_r;

  always #5 clk = ~clk;

  ultrasonic_scan_scheduler #(
    .N_SENSORS(4), .CLK_FREQ_MHZ(2), .TRIG_US(10),
    .ECHO_WAIT_US(400), .MAX_ECHO_US(700), .GAP_US(150)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensor_mask(sensor_mask),
    .echo(echo_pin), .trig(trig), .dist_flat(dist_flat), .dist_valid(dist_valid),
    .dist_sel(dist_sel), .err_flags(err_flags), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Sensor model: echo rises 30 us after its trigger falls and stays high echo_w us (0 = silent).
  initial begin : responder
    logic [3:0] tp;
    int k;
    tp = '0;
    forever begin
      @(negedge clk);
      if (rst && tp != 0 && trig == 0) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (tp[i]) k = i;
        if (echo_w[k] > 0) begin
          repeat (60) @(negedge clk);
          echo_r[k] = 1'b1;
          repeat (2 * echo_w[k]) @(negedge clk);
          echo_r[k] = 1'b0;
        end
      end
      tp = trig;
    end
  end

  always @(negedge clk) begin
    if (trig != 0) begin
      if (tm_prev == 0) begin
        rises_total++;
        tw = 0;
        for (int i = 0; i < 4; i++) if (trig[i]) rise_cnt[i]++;
      end
      tw++;
      if ((trig & (trig - 4'd1)) != 0) multi_hot++;
    end else if (tm_prev != 0) begin
      last_tw = tw;
    end
    tm_prev = trig;
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (dist_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_store(input string tag, input int sel, input logic [15:0] val);
    bit ok;
    wait_valid(ok);
    check_eq({tag, "_sel"}, 64'(dist_sel), 64'(sel));
    check_eq({tag, "_val"}, 64'(dist_flat[16*sel +: 16]), 64'(val));
  endtask

  task automatic wait_trig_fall(input int s);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = trig[s];
    end
    if (!seen) check_eq("trig_rise_timeout", 64'd0, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = (trig == 0);
    end
    if (!seen) check_eq("trig_fall_timeout", 64'd0, 64'd1);
  endtask

  initial begin : main
    int  n;
    int  snap;
    bit  ok;
    rst = 1'b0;
    enable = 1'b0;
    sensor_mask = '0;
    for (int i = 0; i < 4; i++) echo_w[i] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_trig", 64'(trig), 64'd0);
    check_eq("rst_dist", dist_flat, 64'd0);
    check_eq("rst_valid", 64'(dist_valid), 64'd0);
    check_eq("rst_sel", 64'(dist_sel), 64'd0);
    check_eq("rst_err", 64'(err_flags), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // Single sensor, 600 us echo -> 10 cm.
    rst = 1'b1;
    sensor_mask = 4'b0001;
    echo_w[0] = 600;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check_eq("first_trig", 64'(trig), 64'b0001);
    check_eq("busy_on", 64'(busy), 64'd1);
    expect_store("t1", 0, 16'd10);
    check_eq("t1_err", 64'(err_flags), 64'd0);
    @(negedge clk);
    check_eq("valid_one_cycle", 64'(dist_valid), 64'd0);
    check_eq("trig_width", 64'(last_tw), 64'd20);

    // Mask 1011: sensor 2 is skipped, order continues from ptr=1.
    sensor_mask = 4'b1011;
    echo_w[0] = 130;
    echo_w[1] = 300;
    echo_w[2] = 30;
    echo_w[3] = 600;
    for (int i = 0; i < 6; i++) expect_store($sformatf("rr%0d", i), exp_sel[i], 16'(exp_val[i]));
    check_eq("s2_never_trig", 64'(rise_cnt[2]), 64'd0);
    check_eq("s2_slot", 64'(dist_flat[47:32]), 64'd0);
    check_eq("rr_err", 64'(err_flags), 64'd0);

    // Silent sensor 1 times out 400 us after its trigger falls.
    echo_w[1] = 0;
    wait_trig_fall(1);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (dist_valid) break;
    end
    check_eq("timeout_time", 64'(n >= 796 && n <= 806), 64'd1);
    check_eq("timeout_sel", 64'(dist_sel), 64'd1);
    check_eq("timeout_val", 64'(dist_flat[31:16]), 64'hFFFF);
    check_eq("timeout_err", 64'(err_flags), 64'b0010);
    echo_w[1] = 300;
    expect_store("t4_s3", 3, 16'd10);
    check_eq("err1_sticky", 64'(err_flags[1]), 64'd1);
    echo_w[3] = 800;
    expect_store("t4_s0", 0, 16'd2);
    expect_store("t4_retry", 1, 16'd5);
    check_eq("err1_cleared", 64'(err_flags), 64'd0);

    // 800 us echo on sensor 3 overranges at 700 us; the scan then carries on.
    expect_store("ovr", 3, 16'hFFFF);
    check_eq("ovr_err", 64'(err_flags), 64'b1000);
    check_eq("ovr_busy_gap", 64'(busy), 64'd1);
    expect_store("after_ovr", 0, 16'd2);
    check_eq("after_ovr_err", 64'(err_flags), 64'b1000);
    echo_w[3] = 600;

    // Asynchronous reset in the middle of sensor 1's echo.
    wait_trig_fall(1);
    repeat (260) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_trig", 64'(trig), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_dist", dist_flat, 64'd0);
    check_eq("arst_err", 64'(err_flags), 64'd0);
    check_eq("arst_sel", 64'(dist_sel), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (echo_r == 0);
    end
    if (!ok) check_eq("echo_idle_timeout", 64'd0, 64'd1);
    rst = 1'b1;
    expect_store("restart", 0, 16'd2);

    // Dropping enable during a trigger lets that measurement and its gap finish.
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (trig != 0);
    end
    check_eq("dis_trig_seen", 64'(trig), 64'b0010);
    enable = 1'b0;
    expect_store("dis_last", 1, 16'd5);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
    check_eq("dis_gap_len", 64'(n >= 295 && n <= 305), 64'd1);
    snap = rises_total;
    repeat (1000) @(negedge clk);
    check_eq("dis_no_trig", 64'(rises_total), 64'(snap));
    check_eq("dis_idle", 64'(busy), 64'd0);
    check_eq("one_hot_trig", 64'(multi_hot), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
